// File: rtl/al_dram_pkg.sv
// Shared sizing helpers and constants for the distributed-RAM FIFO.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package al_dram_pkg;

    // Default address width; depth is 2**ADDR_WIDTH words.
    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_DEPTH      = 1 << DEFAULT_ADDR_WIDTH;

    // Legal almost-full threshold range is AFULL_LEVEL_MIN .. depth-AFULL_LEVEL_TOP_GAP.
    localparam int AFULL_LEVEL_MIN     = 1;
    localparam int AFULL_LEVEL_TOP_GAP = 1;

    // Occupancy counter needs one bit more than the address to hold "depth".
    function automatic int cnt_width(input int aw);
        return aw + 1;
    endfunction

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    function automatic int afull_max(input int aw);
        return depth_of(aw) - AFULL_LEVEL_TOP_GAP;
    endfunction

    // Pins an out-of-range threshold to the nearest legal value.
    function automatic int afull_clamp(input int lvl, input int aw);
        if (lvl < AFULL_LEVEL_MIN) return AFULL_LEVEL_MIN;
        if (lvl > afull_max(aw))   return afull_max(aw);
        return lvl;
    endfunction

endpackage

// File: rtl/al_logic_dram_mem.sv
// DATA_WIDTH x 2**ADDR_WIDTH storage array, synchronous write, asynchronous read.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller decides when a write is legal.
module al_logic_dram_mem #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_dat_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_dat_o
);

    logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_WIDTH];

    // Storage is intentionally not reset so it maps onto LUT RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/al_logic_dram_fifo.sv
// Synchronous FIFO on distributed RAM with registered occupancy flags and overflow/underflow pulses.
// Latency: 1-cycle read data in standard mode; with AL_DRAM_FIFO_FWFT_EN, head word shown combinationally.
// Backpressure: writes rejected while full, reads rejected while empty; each rejection pulses overflow/underflow.
module al_logic_dram_fifo
    import al_dram_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                CW      = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0]     DEPTH_C = CW'(depth_of(ADDR_WIDTH));
    localparam logic [CW-1:0]     AFULL_C = CW'(afull_clamp(AFULL_LEVEL, ADDR_WIDTH));

    // Pointers carry an extra wrap bit above the address.
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, full_q, afull_q;
    logic                  ovf_q, unf_q;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rd_dat;

    // Accept decisions use the registered flags, so a full FIFO still drains and an empty one still fills.
    always_comb begin
        wr_acc  = wr_en & ~full_q;
        rd_acc  = rd_en & ~empty_q;
        wptr_d  = wptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
        rptr_d  = rptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and flag state; flags are computed from the next count so they settle with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == DEPTH_C);
            afull_q <= (count_d >= AFULL_C);
            ovf_q   <= wr_en & full_q;
            unf_q   <= rd_en & empty_q;
        end
    end

    // A write coinciding with reset is dropped rather than landing in the array.
    al_logic_dram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_acc & ~rst),
        .wr_addr_i (wptr_q[ADDR_WIDTH-1:0]),
        .wr_dat_i  (din),
        .rd_addr_i (rptr_q[ADDR_WIDTH-1:0]),
        .rd_dat_o  (rd_dat)
    );

`ifdef AL_DRAM_FIFO_FWFT_EN
    // Head word falls through; blank while there is nothing to show.
    assign dout = empty_q ? '0 : rd_dat;
`else
    logic [DATA_WIDTH-1:0] dout_q;

    // Capture the head word on the edge that pops it, hold it otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= rd_dat;
        end
    end

    assign dout = dout_q;
`endif

    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = afull_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule
